// File: rtl/f_d_reg_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// decode-stage register layout used by the fetch/decode boundary.
package f_d_reg_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SADR    = 3'd2;
  localparam logic [2:0] SINS    = 3'd3;
  localparam logic [2:0] SHLT    = 3'd4;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] val_c;
    logic [63:0] val_p;
    logic [2:0]  stat;
  } d_reg_t;

  // Contents of an empty decode slot: a NOP that names no registers.
  localparam d_reg_t D_BUBBLE = '{
    icode: INOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    val_c: 64'h0,
    val_p: 64'h0,
    stat:  SAOK
  };

endpackage

// File: rtl/f_d_reg_select_pc.sv
// Fetch PC selection: a mispredicted jump redirects first, then a return
// address from write-back, otherwise the predicted PC.
module select_pc
  import f_d_reg_pkg::*;
(
  input  logic [3:0]  m_icode,
  input  logic        m_cnd,
  input  logic [63:0] m_val_a,
  input  logic [3:0]  w_icode,
  input  logic [63:0] w_val_m,
  input  logic [63:0] pred_pc,
  output logic [63:0] pc
);

  // NOTE: assign a default before any branch so no path leaves pc unassigned
  // and a latch cannot be inferred.
  always_comb begin
    pc = pred_pc;
    if (m_icode == IJXX && !m_cnd) begin
      pc = m_val_a;
    end else if (w_icode == IRET) begin
      pc = w_val_m;
    end
  end

endmodule

// File: rtl/f_d_reg.sv
// Fetch/decode pipeline boundary: predicted-PC register, decode register with
// stall/bubble control, accepted-instruction counter and control-error flag.
module f_d_reg
  import f_d_reg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] f_predPC_i,
  input  logic [3:0]  f_icode_i,
  input  logic [3:0]  f_ifun_i,
  input  logic [3:0]  f_rA_i,
  input  logic [3:0]  f_rB_i,
  input  logic [63:0] f_valC_i,
  input  logic [63:0] f_valP_i,
  input  logic [2:0]  f_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_Cnd_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [63:0] W_valM_i,
  input  logic        F_stall_i,
  input  logic        D_stall_i,
  input  logic        D_bubble_i,
  output logic [63:0] f_pc_o,
  output logic [3:0]  D_icode_o,
  output logic [3:0]  D_ifun_o,
  output logic [3:0]  D_rA_o,
  output logic [3:0]  D_rB_o,
  output logic [63:0] D_valC_o,
  output logic [63:0] D_valP_o,
  output logic [2:0]  D_stat_o,
  output logic [31:0] fetch_cnt_o,
  output logic        ctrl_err_o
);

  logic [63:0] pred_pc_q;
  d_reg_t      d_q;
  d_reg_t      f_fields;
  logic [31:0] fetch_cnt_q;
  logic        ctrl_err_q;
  logic        normal_load;

  assign f_fields = '{
    icode: f_icode_i,
    ifun:  f_ifun_i,
    ra:    f_rA_i,
    rb:    f_rB_i,
    val_c: f_valC_i,
    val_p: f_valP_i,
    stat:  f_stat_i
  };

  // Stall wins over bubble, so a normal load needs both controls low.
  assign normal_load = !D_stall_i && !D_bubble_i;

  select_pc u_select_pc (
    .m_icode (M_icode_i),
    .m_cnd   (M_Cnd_i),
    .m_val_a (M_valA_i),
    .w_icode (W_icode_i),
    .w_val_m (W_valM_i),
    .pred_pc (pred_pc_q),
    .pc      (f_pc_o)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_pc_q   <= 64'h0;
      d_q         <= D_BUBBLE;
      fetch_cnt_q <= 32'h0;
      ctrl_err_q  <= 1'b0;
    end else begin
      if (!F_stall_i) begin
        pred_pc_q <= f_predPC_i;
      end

      if (normal_load) begin
        d_q <= f_fields;
      end else if (!D_stall_i) begin
        d_q <= D_BUBBLE;
      end

      if (normal_load && f_icode_i != INOP && fetch_cnt_q != CNT_MAX) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end

      if (D_stall_i && D_bubble_i) begin
        ctrl_err_q <= 1'b1;
      end
    end
  end

  assign D_icode_o   = d_q.icode;
  assign D_ifun_o    = d_q.ifun;
  assign D_rA_o      = d_q.ra;
  assign D_rB_o      = d_q.rb;
  assign D_valC_o    = d_q.val_c;
  assign D_valP_o    = d_q.val_p;
  assign D_stat_o    = d_q.stat;
  assign fetch_cnt_o = fetch_cnt_q;
  assign ctrl_err_o  = ctrl_err_q;

endmodule

// File: tb/tb_f_d_reg.sv
// Directed bench for f_d_reg: expected decode state is pushed to a queue as
// each edge is driven and popped for comparison after the edge.
module tb_f_d_reg;
  import f_d_reg_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] f_predPC_i;
  logic [3:0]  f_icode_i, f_ifun_i, f_rA_i, f_rB_i;
  logic [63:0] f_valC_i, f_valP_i;
  logic [2:0]  f_stat_i;
  logic [3:0]  M_icode_i;
  logic        M_Cnd_i;
  logic [63:0] M_valA_i;
  logic [3:0]  W_icode_i;
  logic [63:0] W_valM_i;
  logic        F_stall_i, D_stall_i, D_bubble_i;
  logic [63:0] f_pc_o;
  logic [3:0]  D_icode_o, D_ifun_o, D_rA_o, D_rB_o;
  logic [63:0] D_valC_o, D_valP_o;
  logic [2:0]  D_stat_o;
  logic [31:0] fetch_cnt_o;
  logic        ctrl_err_o;

  typedef struct {
    d_reg_t      d;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  d_reg_t      m_d;
  logic [31:0] m_cnt;
  logic        m_err;
  logic [63:0] m_pred;
  int          n_tests = 0;
  int          n_fail  = 0;

  f_d_reg dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .f_predPC_i(f_predPC_i), .f_icode_i(f_icode_i), .f_ifun_i(f_ifun_i),
    .f_rA_i(f_rA_i), .f_rB_i(f_rB_i), .f_valC_i(f_valC_i), .f_valP_i(f_valP_i),
    .f_stat_i(f_stat_i), .M_icode_i(M_icode_i), .M_Cnd_i(M_Cnd_i),
    .M_valA_i(M_valA_i), .W_icode_i(W_icode_i), .W_valM_i(W_valM_i),
    .F_stall_i(F_stall_i), .D_stall_i(D_stall_i), .D_bubble_i(D_bubble_i),
    .f_pc_o(f_pc_o), .D_icode_o(D_icode_o), .D_ifun_o(D_ifun_o),
    .D_rA_o(D_rA_o), .D_rB_o(D_rB_o), .D_valC_o(D_valC_o), .D_valP_o(D_valP_o),
    .D_stat_o(D_stat_o), .fetch_cnt_o(fetch_cnt_o), .ctrl_err_o(ctrl_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected fetch PC from the bench's own view of the inputs and F_predPC.
  function automatic logic [63:0] exp_pc();
    if (M_icode_i == IJXX && M_Cnd_i == 1'b0) return M_valA_i;
    if (W_icode_i == IRET) return W_valM_i;
    return m_pred;
  endfunction

  task automatic set_f(input logic [63:0] pred, input logic [3:0] icode,
                       input logic [3:0] ifun, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp, input logic [2:0] stat);
    f_predPC_i = pred; f_icode_i = icode; f_ifun_i = ifun; f_rA_i = ra; f_rB_i = rb;
    f_valC_i = valc; f_valP_i = valp; f_stat_i = stat;
  endtask

  task automatic compare_d(input string tag, input exp_t e);
    check({tag, ".icode"}, {60'h0, D_icode_o}, {60'h0, e.d.icode});
    check({tag, ".ifun"},  {60'h0, D_ifun_o},  {60'h0, e.d.ifun});
    check({tag, ".rA"},    {60'h0, D_rA_o},    {60'h0, e.d.ra});
    check({tag, ".rB"},    {60'h0, D_rB_o},    {60'h0, e.d.rb});
    check({tag, ".valC"},  D_valC_o,           e.d.val_c);
    check({tag, ".valP"},  D_valP_o,           e.d.val_p);
    check({tag, ".stat"},  {61'h0, D_stat_o},  {61'h0, e.d.stat});
    check({tag, ".cnt"},   {32'h0, fetch_cnt_o}, {32'h0, e.cnt});
    check({tag, ".err"},   {63'h0, ctrl_err_o},  {63'h0, e.err});
  endtask

  // Drive one edge: model the spec'd next state, queue it, then compare.
  task automatic step(input string tag);
    exp_t e;
    if (!F_stall_i) m_pred = f_predPC_i;
    if (!D_stall_i && !D_bubble_i) begin
      m_d = '{icode: f_icode_i, ifun: f_ifun_i, ra: f_rA_i, rb: f_rB_i,
              val_c: f_valC_i, val_p: f_valP_i, stat: f_stat_i};
      if (f_icode_i != INOP && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end else if (!D_stall_i) begin
      m_d = '{icode: INOP, ifun: 4'h0, ra: 4'hF, rb: 4'hF, val_c: 64'h0, val_p: 64'h0, stat: SAOK};
    end
    if (D_stall_i && D_bubble_i) m_err = 1'b1;
    e.d = m_d; e.cnt = m_cnt; e.err = m_err;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $error("FAIL %s: scoreboard empty observed 0 expected 1", tag);
    end else begin
      compare_d(tag, sb.pop_front());
      check({tag, ".pc"}, f_pc_o, exp_pc());
    end
  endtask

  task automatic reset_model();
    m_d = '{icode: INOP, ifun: 4'h0, ra: 4'hF, rb: 4'hF, val_c: 64'h0, val_p: 64'h0, stat: SAOK};
    m_cnt = 32'h0; m_err = 1'b0; m_pred = 64'h0;
  endtask

  initial begin
    exp_t e;
    rst_i = 1'b1;
    set_f(64'h0, INOP, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, SAOK);
    M_icode_i = INOP; M_Cnd_i = 1'b1; M_valA_i = 64'h0;
    W_icode_i = INOP; W_valM_i = 64'h0;
    F_stall_i = 1'b0; D_stall_i = 1'b0; D_bubble_i = 1'b0;
    reset_model();

    // Reset state, then PC overrides still work while reset is held.
    #12;
    e.d = m_d; e.cnt = m_cnt; e.err = m_err;
    compare_d("reset", e);
    check("reset.pc", f_pc_o, 64'h0);
    M_icode_i = IJXX; M_Cnd_i = 1'b0; M_valA_i = 64'h123;
    #1 check("reset.pc_mispredict", f_pc_o, 64'h123);
    M_icode_i = INOP; M_Cnd_i = 1'b1;

    @(negedge clk_i);
    rst_i = 1'b0;
    set_f(64'h0A, IIRMOVQ, 4'h0, 4'hF, 4'h3, 64'h1111, 64'h0A, SAOK);
    step("first_load");
    check("first_load.pc_0a", f_pc_o, 64'h0A);
    check("first_load.cnt_1", {32'h0, fetch_cnt_o}, 64'h1);

    // PC selection priority.
    M_icode_i = IJXX; M_Cnd_i = 1'b0; M_valA_i = 64'h40;
    W_icode_i = IRET; W_valM_i = 64'h80;
    #1 check("sel.mispredict_over_ret", f_pc_o, 64'h40);
    M_icode_i = IOPQ;
    #1 check("sel.ret", f_pc_o, 64'h80);
    M_icode_i = IJXX; M_Cnd_i = 1'b1;
    #1 check("sel.taken_jump_ret", f_pc_o, 64'h80);
    W_icode_i = IPOPQ;
    #1 check("sel.pred", f_pc_o, 64'h0A);
    M_icode_i = INOP;

    // Normal loads, including a NOP that must not count.
    set_f(64'h14, IOPQ, 4'h1, 4'h2, 4'h3, 64'h0, 64'h0C, SAOK);
    step("load_opq");
    set_f(64'h16, INOP, 4'h0, 4'hF, 4'hF, 64'h0, 64'h15, SAOK);
    step("load_nop");
    set_f(64'h20, ICALL, 4'h0, 4'hF, 4'hF, 64'hDEAD_BEEF_0000_0040, 64'h1F, SAOK);
    step("load_call");

    // Decode stall for three cycles while fetch keeps moving.
    D_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_f(64'h100 + 64'(i), IRMMOVQ, 4'(i), 4'h5, 4'h6, 64'(i * 7), 64'h30 + 64'(i), SADR);
      step($sformatf("stall%0d", i));
    end
    D_stall_i = 1'b0;
    set_f(64'h200, IMRMOVQ, 4'h0, 4'h7, 4'h8, 64'h99, 64'h3A, SAOK);
    step("stall_release");

    // Bubble with fetch stalled.
    F_stall_i = 1'b1; D_bubble_i = 1'b1;
    set_f(64'h300, IPUSHQ, 4'h0, 4'h1, 4'hF, 64'h0, 64'h44, SAOK);
    step("bubble_fstall");
    check("bubble_fstall.pred_held", f_pc_o, 64'h200);
    F_stall_i = 1'b0; D_bubble_i = 1'b0;

    // Halted status in D still obeys a bubble.
    set_f(64'h310, IHALT, 4'h0, 4'hF, 4'hF, 64'h0, 64'h311, SHLT);
    step("load_halt");
    D_bubble_i = 1'b1;
    step("bubble_after_halt");
    D_bubble_i = 1'b0;

    // Stall+bubble conflict: hold, flag sticks.
    set_f(64'h400, IRRMOVQ, 4'h0, 4'h1, 4'h2, 64'h0, 64'h402, SAOK);
    step("pre_conflict");
    D_stall_i = 1'b1; D_bubble_i = 1'b1;
    set_f(64'h410, IOPQ, 4'h3, 4'h4, 4'h5, 64'h0, 64'h412, SINS);
    step("conflict");
    D_stall_i = 1'b0; D_bubble_i = 1'b0;
    step("conflict_sticky");

    // Counter saturation from a preset value.
    @(negedge clk_i);
    force dut.fetch_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.fetch_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      set_f(64'h500 + 64'(i), IIRMOVQ, 4'h0, 4'hF, 4'(i), 64'(i), 64'h50A + 64'(i), SAOK);
      step($sformatf("sat%0d", i));
    end
    check("sat.final", {32'h0, fetch_cnt_o}, 64'hFFFF_FFFF);

    // Asynchronous reset mid-cycle during a stall.
    D_stall_i = 1'b1;
    step("stall_before_rst");
    #2 rst_i = 1'b1;
    #1;
    reset_model();
    e.d = m_d; e.cnt = m_cnt; e.err = m_err;
    compare_d("async_rst", e);
    check("async_rst.pc", f_pc_o, 64'h0);
    #1 rst_i = 1'b0;
    D_stall_i = 1'b0;
    set_f(64'h600, IPOPQ, 4'h0, 4'h4, 4'hF, 64'h0, 64'h602, SAOK);
    step("after_rst_load");

    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/f_d_reg.md
F_D_REG -- requirements
Module: f_d_reg

Interface
REQ-001 SHALL provide ports, clock and reset first: clk_i in 1, single clock, all state updates on rising edge; rst_i in 1, reset, asynchronous, active-high.
REQ-002 SHALL provide f_predPC_i in 64 (predicted next PC from fetch) and f_icode_i in 4, f_ifun_i in 4, f_rA_i in 4, f_rB_i in 4, f_valC_i in 64, f_valP_i in 64, f_stat_i in 3 (fetch outputs).
REQ-003 SHALL provide M_icode_i in 4, M_Cnd_i in 1, M_valA_i in 64 (memory-stage branch info) and W_icode_i in 4, W_valM_i in 64 (write-back return address).
REQ-004 SHALL provide F_stall_i in 1, D_stall_i in 1, D_bubble_i in 1 (pipeline control).
REQ-005 SHALL provide f_pc_o out 64 (selected PC driven to fetch PC_i).
REQ-006 SHALL provide D_icode_o out 4, D_ifun_o out 4, D_rA_o out 4, D_rB_o out 4, D_valC_o out 64, D_valP_o out 64, D_stat_o out 3 (decode-stage register).
REQ-007 SHALL provide fetch_cnt_o out 32 (instructions accepted into D) and ctrl_err_o out 1 (stall/bubble conflict seen).

Function
REQ-008 SHALL hold F_predPC register; loads f_predPC_i each edge unless F_stall_i=1.
REQ-009 SHALL compute f_pc_o combinationally: M_icode_i=IJXX and M_Cnd_i=0 -> M_valA_i; else W_icode_i=IRET -> W_valM_i; else F_predPC.
REQ-010 SHALL give mispredict selection priority over IRET when both hold in one cycle.
REQ-011 SHALL load D register from f_* inputs when D_stall_i=0 and D_bubble_i=0 (latency 1 cycle fetch->D).
REQ-012 SHALL hold all D fields unchanged when D_stall_i=1.
REQ-013 SHALL load bubble when D_bubble_i=1 and D_stall_i=0: icode INOP, ifun 0, rA F, rB F, valC 0, valP 0, stat SAOK.
REQ-014 SHALL treat D_stall_i=1 with D_bubble_i=1 as stall (hold) and set ctrl_err_o=1 on the next edge; ctrl_err_o sticky until reset.
REQ-015 SHALL increment fetch_cnt_o by 1 on each edge performing a normal load (REQ-011) with f_icode_i not INOP; saturate at 32'hFFFF_FFFF, no wrap.
REQ-016 SHALL, once D_stat_o is SHLT, SADR or SINS, still obey stall/bubble; no freeze inside this block (freezing is pipeline-control duty).
REQ-017 SHALL apply F_stall_i independently of D controls (F stall with D bubble legal: PC holds, D gets bubble).

Reset
REQ-018 SHALL on rst_i=1, asynchronously: F_predPC=0, D register = bubble values (REQ-013), fetch_cnt_o=0, ctrl_err_o=0.
REQ-019 SHALL, with reset asserted, drive f_pc_o from selection logic using F_predPC=0 (so f_pc_o=0 unless M/W override).
REQ-020 SHALL resume normal loading on the first rising edge after rst_i deasserts; reset mid-stall discards held D contents.

Structure
REQ-021 SHALL take icode constants (IHALT, INOP, IJXX, ICALL, IRET, ...) and stat codes (SAOK, SHLT, SADR, SINS) from the shared define.v package; no local duplicates.
REQ-022 SHALL place PC selection in sub-module select_pc (pure combinational); registers, bubble injection and counter in f_d_reg.

Verification
REQ-023 Reset then release, f_predPC_i=0x0A, f_icode_i=IIRMOVQ, no controls -> after 1 edge f_pc_o=0x0A, D_icode_o=IIRMOVQ, fetch_cnt_o=1.
REQ-024 M_icode_i=IJXX, M_Cnd_i=0, M_valA_i=0x40, W_icode_i=IRET, W_valM_i=0x80 -> f_pc_o=0x40; drop M -> f_pc_o=0x80.
REQ-025 D_stall_i=1 for 3 cycles with changing f_* -> D fields and fetch_cnt_o unchanged; release -> next edge loads current f_*.
REQ-026 D_bubble_i=1 with F_stall_i=1 -> D_icode_o=INOP, D_rA_o=F, D_stat_o=SAOK, F_predPC held, counter unchanged.
REQ-027 D_stall_i=1 and D_bubble_i=1 together -> D holds, ctrl_err_o=1 and stays 1 until rst_i; counter preset near 32'hFFFF_FFFE plus 3 valid loads -> saturates at 32'hFFFF_FFFF.
REQ-028 Assert rst_i asynchronously mid-cycle during stall -> outputs reach reset values before next clock edge.
